// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_STAGE_PERF_EN.
`default_nettype none

module pipe_stage_skid #(
    parameter int CW_W   = 35,
    parameter int DATA_W = 32,
    parameter int N_DATA = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW_W-1:0]          in_ctrl,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW_W-1:0]          out_ctrl,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
`endif
);

    localparam int DW = N_DATA * DATA_W;

    logic            main_valid_q, main_valid_d;
    logic [CW_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DW-1:0]   main_data_q,  main_data_d;
    logic            skid_valid_q, skid_valid_d;
    logic [CW_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DW-1:0]   skid_data_q,  skid_data_d;

    logic in_fire;
    logic out_fire;

    // in_ready comes straight from a flop so upstream never sees a combinational path.
    assign in_ready  = ~skid_valid_q;
    assign in_fire   = in_valid & ~skid_valid_q;
    assign out_fire  = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            if (skid_valid_q) begin
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                // Emptying: control goes to NOP, data lanes are left as don't-care.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (in_fire) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W:0]   flush_sum;

    assign flush_sum = {1'b0, flush_cnt_q} + {{(CNT_W-1){1'b0}}, occupancy};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush) begin
                flush_cnt_q <= flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: randomized and directed checks of pipe_stage_skid against a 2-deep FIFO model.
`default_nettype none

module tb_pipe_stage_skid;

    localparam int CW_W   = 35;
    localparam int DATA_W = 32;
    localparam int N_DATA = 4;
    localparam int CNT_W  = 4;
    localparam int DW     = N_DATA * DATA_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW_W-1:0] in_ctrl = '0;
    logic [DW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW_W-1:0] out_ctrl;
    logic [DW-1:0]   out_data;
    logic [1:0]      occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    pipe_stage_skid #(
        .CW_W  (CW_W),
        .DATA_W(DATA_W),
        .N_DATA(N_DATA),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW_W-1:0] ctrl;
        logic [DW-1:0]   data;
    } entry_t;

    entry_t mq[$];
    int     m_stall = 0;
    int     m_flush = 0;
    int     checks  = 0;
    int     errors  = 0;

    // Model: a FIFO of at most two entries; accepts only while it held fewer than two.
    task automatic tick();
        entry_t e;
        int     sz;
        sz = mq.size();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (sz > 0 && !out_ready && m_stall < CMAX) m_stall++;
            if (flush) begin
                m_flush = (m_flush + sz > CMAX) ? CMAX : m_flush + sz;
                mq.delete();
            end else begin
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) begin
                    e.ctrl = in_ctrl;
                    e.data = in_data;
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    function automatic logic [CW_W-1:0] exp_ctrl();
        return (mq.size() > 0) ? mq[0].ctrl : '0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 35'h7; in_data = rand_data();
        tick(); tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b ctrl=%h ready=%b occ=%0d data=%h, required 0 0 1 0 0",
                     out_valid, out_ctrl, in_ready, occupancy, out_data);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: stall=%0d flush=%0d, required 0 0", stall_cnt, flush_cnt);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_ctrl  = CW_W'(k);
            in_data  = rand_data();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== CW_W'(k) || in_ready !== 1'b1 || out_data !== in_data) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b ctrl=%0d ready=%b data=%h, required 1 %0d 1 %h",
                         k, out_valid, out_ctrl, in_ready, out_data, k, in_data);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b ctrl=%h occ=%0d, required 0 0 0", out_valid, out_ctrl, occupancy);
        end
    endtask

    task automatic test_full();
        logic [CW_W-1:0] seq [3];
        seq[0] = 35'h0A; seq[1] = 35'h0B; seq[2] = 35'h0C;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_ctrl = seq[k]; in_data = rand_data();
            tick();
        end
        in_ctrl = seq[2]; in_data = rand_data();
        tick(); tick();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== seq[0]) begin
            errors++;
            $display("FAIL full_hold: occ=%0d ready=%b ctrl=%h, required 2 0 %h", occupancy, in_ready, out_ctrl, seq[0]);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            if (k == 2) in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== seq[k] || out_data !== mq[0].data) begin
                errors++;
                $display("FAIL full_order_%0d: valid=%b ctrl=%h, required 1 %h", k, out_valid, out_ctrl, seq[k]);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL full_drain: valid=%b occ=%0d, required 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_ctrl = CW_W'(8 + k); in_data = rand_data();
            tick();
        end
        flush = 1'b1; in_ctrl = 35'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: valid=%b ctrl=%h occ=%0d ready=%b, required 0 0 0 1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
`ifdef PIPE_STAGE_PERF_EN
        checks++;
        if (flush_cnt !== CNT_W'(m_flush) || m_flush != 2) begin
            errors++;
            $display("FAIL flush_cnt: got %0d, required %0d", flush_cnt, m_flush);
        end
`endif
        tick();
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d5;
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 35'h4; in_data = rand_data();
        tick();
        d5 = rand_data();
        in_ctrl = 35'h5; in_data = d5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_ctrl !== 35'h5 || occupancy !== 2'd1 || out_data !== d5 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul: ctrl=%h occ=%0d ready=%b, required 5 1 1", out_ctrl, occupancy, in_ready);
        end
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_stall_sat();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 35'h9; in_data = rand_data();
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (stall_cnt !== 4'd15 || m_stall != 15) begin
            errors++;
            $display("FAIL stall_sat: got %0d, required 15 (model %0d)", stall_cnt, m_stall);
        end
        out_ready = 1'b1;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [CW_W-1:0] ec;
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_ctrl   = {$urandom, $urandom};
            in_data   = rand_data();
            tick();
            ec = exp_ctrl();
            checks++;
            if (out_valid !== (mq.size() > 0) || out_ctrl !== ec || occupancy !== 2'(mq.size())
                || in_ready !== (mq.size() < 2) || (mq.size() > 0 && out_data !== mq[0].data)) begin
                errors++;
                $display("FAIL random_%0d: valid=%b ctrl=%h occ=%0d ready=%b, required %b %h %0d %b",
                         n, out_valid, out_ctrl, occupancy, in_ready,
                         mq.size() > 0, ec, mq.size(), mq.size() < 2);
            end
`ifdef PIPE_STAGE_PERF_EN
            checks++;
            if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                errors++;
                $display("FAIL random_cnt_%0d: stall=%0d flush=%0d, required %0d %0d",
                         n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full();
        test_flush();
        test_simultaneous();
`ifdef PIPE_STAGE_PERF_EN
        test_stall_sat();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
